// File: rtl/softermax_recip_arbiter.sv
// Round-robin share of one reciprocal pipeline among NUM_REQ row engines; results return in issue order.
// Zero added latency on both paths; a stalled head owner blocks every return. Optional stats: SOFTERMAX_RECIP_ARB_STATS_EN.
module softermax_recip_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ*IN_WIDTH-1:0]         req_data_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic [OUT_WIDTH-1:0]                resp_data_o,
    output logic [NUM_REQ-1:0]                  resp_valid_o,
    input  logic [NUM_REQ-1:0]                  resp_ready_i,
    output logic [IN_WIDTH-1:0]                 recip_in_data_o,
    output logic                                recip_in_valid_o,
    input  logic                                recip_in_ready_i,
    input  logic [OUT_WIDTH-1:0]                recip_out_data_i,
    input  logic                                recip_out_valid_i,
    output logic                                recip_out_ready_o,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
    output logic                                proto_err_o
`ifdef SOFTERMAX_RECIP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]               issue_count_o,
    output logic [15:0]                         stall_cycles_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ARB, HOLD} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   lock_idx_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               proto_err_q;
    logic [IDX_W-1:0]   tag_mem_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   cand;
    logic               any_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [IDX_W-1:0]   head_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        scan_idx = '0;
        cand     = '0;
        any_vld  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid_i[scan_idx]) begin
                any_vld = 1'b1;
                cand    = scan_idx;
            end
        end
    end

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // HOLD pins the grant so the operand on the reciprocal input cannot change before it is taken.
    assign gnt_idx  = (state_q == HOLD) ? lock_idx_q : cand;
    assign gnt_vld  = ((state_q == HOLD) ? req_valid_i[lock_idx_q] : any_vld) && !fifo_full;
    assign rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    assign push     = gnt_vld && recip_in_ready_i;

    assign recip_in_valid_o = gnt_vld;
    assign recip_in_data_o  = req_data_i[gnt_idx*IN_WIDTH +: IN_WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (gnt_vld) begin
            req_ready_o[gnt_idx] = recip_in_ready_i;
        end
    end

    assign head_idx          = tag_mem_q[rd_ptr_q];
    assign recip_out_ready_o = !fifo_empty && resp_ready_i[head_idx];
    assign pop               = recip_out_valid_i && recip_out_ready_o;
    assign resp_data_o       = recip_out_data_i;

    always_comb begin
        resp_valid_o = '0;
        if (recip_out_valid_i && !fifo_empty) begin
            resp_valid_o[head_idx] = 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign proto_err_o   = proto_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == ARB) begin
                if (gnt_vld) begin
                    if (recip_in_ready_i) begin
                        rr_ptr_q <= rr_ptr_d;
                    end else begin
                        lock_idx_q <= cand;
                        state_q    <= HOLD;
                    end
                end
            end else begin
                if (push) begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ARB;
                end else if (!req_valid_i[lock_idx_q]) begin
                    state_q <= ARB;
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end

            if (recip_out_valid_i && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

`ifdef SOFTERMAX_RECIP_ARB_STATS_EN
    logic [15:0] issue_cnt_q [NUM_REQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                issue_cnt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push && (gnt_idx == IDX_W'(i)) && (issue_cnt_q[i] != 16'hFFFF)) begin
                    issue_cnt_q[i] <= issue_cnt_q[i] + 16'd1;
                end
            end
            if ((|req_valid_i) && fifo_full && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign issue_count_o[g*16 +: 16] = issue_cnt_q[g];
    end
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_softermax_recip_arbiter.sv
// Bench for softermax_recip_arbiter: requester drivers, a reciprocal pipeline stand-in and an in-order scoreboard.
`timescale 1ns/1ps
module tb_softermax_recip_arbiter;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*8-1:0]   req_data;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [7:0]        resp_data;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [7:0]        recip_in_data;
    logic              recip_in_valid;
    logic              recip_in_ready;
    logic [7:0]        recip_out_data;
    logic              recip_out_valid;
    logic              recip_out_ready;
    logic [3:0]        outstanding;
    logic              proto_err;
`ifdef SOFTERMAX_RECIP_ARB_STATS_EN
    logic [NR*16-1:0]  issue_count;
    logic [15:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    softermax_recip_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .resp_data_o(resp_data), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .recip_in_data_o(recip_in_data), .recip_in_valid_o(recip_in_valid), .recip_in_ready_i(recip_in_ready),
        .recip_out_data_i(recip_out_data), .recip_out_valid_i(recip_out_valid), .recip_out_ready_o(recip_out_ready),
        .outstanding_o(outstanding), .proto_err_o(proto_err)
`ifdef SOFTERMAX_RECIP_ARB_STATS_EN
        , .issue_count_o(issue_count), .stall_cycles_o(stall_cycles)
`endif
    );

    typedef struct {int req; logic [7:0] op; logic [7:0] res;} vec_t;
    typedef struct {int idx; logic [7:0] exp;} sb_t;
    typedef struct {logic [7:0] d; int t;} stub_t;

    vec_t       tbl [8];
    sb_t        sb_q [$];
    sb_t        sb_e;
    stub_t      stub_q [$];
    int         issue_log [$];
    logic [7:0] rq_op [NR][16];
    logic [7:0] rq_ex [NR][16];
    int         rq_hd [NR];
    int         rq_n [NR];
    logic [7:0] man_exp [NR];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc_cnt = 0;
    bit         auto_drv = 1'b0;
    bit         stub_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Q4.4 operand -> Q3.5 reciprocal, saturating.
    function automatic logic [7:0] rfn(input logic [7:0] x);
        int q;
        if (x == 8'd0) return 8'hFF;
        q = 512 / int'(x);
        return (q > 255) ? 8'hFF : 8'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tb();
        sb_q.delete();
        stub_q.delete();
        issue_log.delete();
        for (int i = 0; i < NR; i++) begin
            rq_hd[i] = 0;
            rq_n[i]  = 0;
        end
    endtask

    task automatic load(input int r, input logic [7:0] op, input logic [7:0] ex);
        rq_op[r][rq_n[r]] = op;
        rq_ex[r][rq_n[r]] = ex;
        rq_n[r]++;
    endtask

    task automatic wait_drain(input string name);
        bit fed;
        fed = 1'b0;
        for (int k = 0; k < 200; k++) begin
            fed = (sb_q.size() == 0) && (stub_q.size() == 0);
            for (int i = 0; i < NR; i++) if (rq_hd[i] != rq_n[i]) fed = 1'b0;
            if (fed) break;
            @(negedge clk);
        end
        chk({name, "_drain"}, 32'(fed), 32'd1);
    endtask

    // Monitor: records issues, checks returns, models the reciprocal pipeline contents.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("outstanding_model", 32'(outstanding), 32'(sb_q.size()));
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("resp_valid_onehot", 32'($countones(resp_valid) <= 1), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    chk("issue_data", 32'(recip_in_data), 32'(req_data[i*8 +: 8]));
                    sb_e.idx = i;
                    sb_e.exp = auto_drv ? rq_ex[i][rq_hd[i]] : man_exp[i];
                    sb_q.push_back(sb_e);
                    issue_log.push_back(i);
                    if (auto_drv) rq_hd[i]++;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb_q.size() == 0) begin
                        chk("resp_unexpected", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        sb_e = sb_q.pop_front();
                        chk("resp_owner", 32'(i), 32'(sb_e.idx));
                        chk("resp_data", 32'(resp_data), 32'(sb_e.exp));
                    end
                end
            end
            if (stub_en) begin
                if (recip_out_valid && recip_out_ready && stub_q.size() > 0) void'(stub_q.pop_front());
                if (recip_in_valid && recip_in_ready) stub_q.push_back('{rfn(recip_in_data), cyc_cnt + 4});
            end
        end
    end

    // Drivers: reciprocal outputs and automatic requesters change just after the clock edge.
    initial forever begin
        tick();
        cyc_cnt++;
        if (stub_en) begin
            if (stub_q.size() > 0 && stub_q[0].t <= cyc_cnt) begin
                recip_out_valid = 1'b1;
                recip_out_data  = stub_q[0].d;
            end else begin
                recip_out_valid = 1'b0;
                recip_out_data  = 8'h00;
            end
        end
        if (auto_drv) begin
            for (int i = 0; i < NR; i++) begin
                if (rq_hd[i] < rq_n[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = rq_op[i][rq_hd[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 8'h10, 8'h20};
        tbl[1] = '{1, 8'h20, 8'h10};
        tbl[2] = '{2, 8'h08, 8'h40};
        tbl[3] = '{3, 8'h40, 8'h08};
        tbl[4] = '{0, 8'h04, 8'h80};
        tbl[5] = '{1, 8'h80, 8'h04};
        tbl[6] = '{2, 8'h02, 8'hFF};
        tbl[7] = '{3, 8'h00, 8'hFF};
        for (int i = 0; i < NR; i++) man_exp[i] = 8'h00;
        clear_tb();

        rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = '1;
        recip_in_ready = 1'b1; recip_out_valid = 1'b0; recip_out_data = 8'h00;
        #12;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_in_valid", 32'(recip_in_valid), 0);
        chk("rst_out_ready", 32'(recip_out_ready), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        tick(); rst_n = 1'b1;

        // Round-robin over the vector table; grants must follow the table order.
        tick();
        for (int k = 0; k < 8; k++) load(tbl[k].req, tbl[k].op, tbl[k].res);
        auto_drv = 1'b1;
        wait_drain("rr");
        chk("rr_issue_count", 32'(issue_log.size()), 8);
        for (int k = 0; k < 8; k++) if (k < issue_log.size()) chk("rr_grant", 32'(issue_log[k]), 32'(tbl[k].req));
        tick(); auto_drv = 1'b0; req_valid = '0; clear_tb();

        // HOLD lock on requester 2 while requester 0 arrives.
        tick(); recip_in_ready = 1'b0; req_data[2*8 +: 8] = 8'h20; man_exp[2] = 8'h10; req_valid = 4'b0100;
        @(negedge clk);
        chk("hold_in_valid", 32'(recip_in_valid), 1);
        chk("hold_in_data", 32'(recip_in_data), 32'h20);
        chk("hold_ready_low", 32'(req_ready), 0);
        tick(); req_data[0 +: 8] = 8'h10; man_exp[0] = 8'h20; req_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_data_stable", 32'(recip_in_data), 32'h20);
            if (c < 2) tick();
        end
        tick(); recip_in_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_gnt", 32'(req_ready), 32'b0100);
        tick(); req_data[2*8 +: 8] = 8'h40; man_exp[2] = 8'h08;
        @(negedge clk);
        chk("hold_wrap_gnt", 32'(req_ready), 32'b0001);
        chk("hold_wrap_data", 32'(recip_in_data), 32'h10);
        tick(); req_valid = 4'b0100;
        @(negedge clk);
        chk("hold_next_gnt", 32'(req_ready), 32'b0100);
        tick(); req_valid = '0;
        wait_drain("hold");

        // Full FIFO: pop and pending request in the same cycle must not push.
        tick(); clear_tb(); resp_ready = '0;
        for (int k = 0; k < 9; k++) load(1, tbl[k % 8].op, tbl[k % 8].res);
        auto_drv = 1'b1;
        for (int k = 0; k < 60 && !(outstanding == 4'd8 && recip_out_valid); k++) @(negedge clk);
        chk("full_count", 32'(outstanding), 8);
        chk("full_in_valid", 32'(recip_in_valid), 0);
        chk("full_req_ready", 32'(req_ready), 0);
        tick(); resp_ready = 4'b0010;
        @(negedge clk);
        chk("full_pop_ready", 32'(recip_out_ready), 1);
        chk("full_no_push", 32'(recip_in_valid), 0);
        tick(); resp_ready = '0;
        @(negedge clk);
        chk("full_push_next", 32'(req_ready), 32'b0010);
        tick();
        @(negedge clk);
        chk("full_refilled", 32'(outstanding), 8);
        tick(); resp_ready = '1;
        wait_drain("full");
        tick(); auto_drv = 1'b0; req_valid = '0; clear_tb();

        // Return backpressure from head owner 1.
        tick(); resp_ready = 4'b1101; load(1, 8'h20, 8'h10); auto_drv = 1'b1;
        for (int k = 0; k < 20 && sb_q.size() == 0; k++) @(negedge clk);
        chk("bp_first_issue", 32'(sb_q.size()), 1);
        tick(); load(2, 8'h08, 8'h40);
        for (int k = 0; k < 20 && !recip_out_valid; k++) @(negedge clk);
        chk("bp_out_valid", 32'(recip_out_valid), 1);
        for (int c = 0; c < 4; c++) begin
            chk("bp_out_ready", 32'(recip_out_ready), 0);
            chk("bp_resp_valid", 32'(resp_valid), 32'b0010);
            chk("bp_resp_data", 32'(resp_data), 32'h10);
            tick();
            @(negedge clk);
        end
        tick(); resp_ready = '1;
        wait_drain("bp");
        tick(); auto_drv = 1'b0; req_valid = '0; clear_tb();

        // Asynchronous reset with three operations in flight.
        tick(); resp_ready = '0;
        load(3, 8'h10, 8'h20); load(3, 8'h20, 8'h10); load(3, 8'h40, 8'h08);
        auto_drv = 1'b1;
        for (int k = 0; k < 40 && outstanding != 4'd3; k++) @(negedge clk);
        chk("rst3_inflight", 32'(outstanding), 3);
        #2; rst_n = 1'b0; #1;
        chk("rst3_outstanding", 32'(outstanding), 0);
        chk("rst3_req_ready", 32'(req_ready), 0);
        chk("rst3_resp_valid", 32'(resp_valid), 0);
        chk("rst3_in_valid", 32'(recip_in_valid), 0);
        chk("rst3_out_ready", 32'(recip_out_ready), 0);
        auto_drv = 1'b0; req_valid = '0; clear_tb();
        tick(); tick(); rst_n = 1'b1; resp_ready = '1;
        tick(); req_data[2*8 +: 8] = 8'h10; man_exp[2] = 8'h20; req_valid = 4'b0100;
        @(negedge clk);
        chk("rst3_first_gnt", 32'(req_ready), 32'b0100);
        tick(); req_valid = '0;
        wait_drain("rst3");

        // Result with nothing outstanding.
        tick();
        chk("proto_clear", 32'(proto_err), 0);
        stub_en = 1'b0; recip_out_valid = 1'b1; recip_out_data = 8'h55;
        @(negedge clk);
        chk("proto_out_ready", 32'(recip_out_ready), 0);
        chk("proto_resp_valid", 32'(resp_valid), 0);
        tick(); recip_out_valid = 1'b0;
        @(negedge clk);
        chk("proto_set", 32'(proto_err), 1);
        tick(); tick(); tick();
        @(negedge clk);
        chk("proto_sticky", 32'(proto_err), 1);
        #2; rst_n = 1'b0; #1;
        chk("proto_reset", 32'(proto_err), 0);
        tick(); rst_n = 1'b1; stub_en = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/softermax_recip_arbiter.md
Name: softermax_recip_arbiter

Overview:
- Shares one softermax_lpw_reciprocal pipeline between NUM_REQ softermax row engines.
- Grants requesters round-robin and tags each issued operand with its requester index in an in-order tag FIFO.
- Steers each reciprocal result back to the requester that issued it.
- Sits between the per-row sum accumulators and the single reciprocal unit.

Parameters:
- NUM_REQ, 4, number of requesters; ≥2.
- IN_WIDTH, 8, operand width; matches reciprocal unit IN_WIDTH.
- OUT_WIDTH, 8, result width; matches reciprocal unit OUT_WIDTH.
- MAX_OUTSTANDING, 8, tag FIFO depth; power of 2, ≥ reciprocal pipeline depth (5) for full throughput.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_data  in  NUM_REQ*IN_WIDTH  packed operands; requester i at bits [i*IN_WIDTH +: IN_WIDTH].
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- resp_data  out  OUT_WIDTH  result, broadcast to all requesters.
- resp_valid  out  NUM_REQ  one-hot or zero valid for the owning requester.
- resp_ready  in  NUM_REQ  per-requester ready.
- recip_in_data  out  IN_WIDTH  operand to the reciprocal unit.
- recip_in_valid  out  1  operand valid.
- recip_in_ready  in  1  reciprocal unit ready.
- recip_out_data  in  OUT_WIDTH  result from the reciprocal unit.
- recip_out_valid  in  1  result valid.
- recip_out_ready  out  1  result ready.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of in-flight operations.
- proto_err  out  1  sticky error: recip_out_valid seen while the tag FIFO was empty.

Behaviour:
- Reset (asynchronous on rst_n low): rr_ptr=0, state=ARB, FIFO empty, outstanding=0, proto_err=0. All outputs are combinational from this state, so req_ready=0, resp_valid=0, recip_in_valid=0, recip_out_ready=0.
- Issue FSM, state ARB:
  - cand = first index i ≥ rr_ptr (mod NUM_REQ) with req_valid[i].
  - If any req_valid and FIFO not full: recip_in_valid=1, recip_in_data=req_data[cand], req_ready[cand]=recip_in_ready.
  - Handshake: push cand into FIFO, rr_ptr <= cand+1 mod NUM_REQ, stay in ARB.
  - Valid but not ready: lock_idx <= cand, go to HOLD.
- Issue FSM, state HOLD:
  - Grant fixed to lock_idx; newly valid higher-priority requesters are ignored. This keeps recip_in_data/valid stable until accepted.
  - Handshake: push lock_idx, rr_ptr <= lock_idx+1, go to ARB.
  - Requesters must hold req_valid/req_data until ready. A requester dropping valid while locked is not supported.
- Full check: FIFO full is taken from the registered count. A pop in the same cycle does not enable a push; no bypass. When full, recip_in_valid=0 and the FSM stays in its current state.
- Return path:
  - head = FIFO head tag.
  - resp_valid[head] = recip_out_valid & !empty; resp_data = recip_out_data passthrough (0 latency).
  - recip_out_ready = !empty & resp_ready[head]. Pop on recip_out_valid & recip_out_ready.
  - Backpressure from one requester stalls all returns; strict in-order delivery.
- Simultaneous push and pop: count unchanged, head advances, tail advances.
- outstanding = FIFO count, registered. Range 0..MAX_OUTSTANDING.
- Error: recip_out_valid with FIFO empty sets proto_err (sticky until reset). recip_out_ready stays 0 in that case.
- Throughput: 1 issue/cycle and 1 return/cycle at steady state.
- Latency: 0 cycles added on either path (combinational steering).

Optional Feature:
- Macro: SOFTERMAX_RECIP_ARB_STATS_EN.
- With macro defined:
  - Adds output issue_count [NUM_REQ*16]: per-requester 16-bit saturating count of accepted operands.
  - Adds output stall_cycles [15:0]: saturating count of cycles with a valid request blocked by a full FIFO.
  - All counters clear on reset.
- Without macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-operation: 3 in flight, assert rst_n=0 → outstanding=0, all valids/readies 0 immediately (asynchronous). After release, first req_valid[2] issues normally.
- Round-robin fairness: all 4 requesters valid continuously, recip_in_ready=1 → grants 0,1,2,3,0,... Each result returns to its issuer in order; the result of 1/x for x=0x10 (1.0 in Q4.4) reaches the right requester as 0x20 (1.0 in Q3.5, OUT_FRAC_WIDTH=5).
- HOLD lock: req 2 valid, recip_in_ready=0 for 3 cycles, req 0 asserts on cycle 1 → grant stays 2 with stable data; after ready, next grant 0 via rr_ptr=3→wrap.
- Full FIFO: recip_out_ready path stalled via resp_ready=0, issue 8 → outstanding=8, recip_in_valid=0. With a pop and pending request in the same cycle, no push that cycle; push next cycle.
- Return backpressure: head owner resp_ready[1]=0 for 4 cycles → recip_out_ready=0, resp_data held, no other requester receives a response.
- Protocol error: recip_out_valid=1 with empty FIFO → proto_err=1, stays 1 until rst_n low.
